tlu_trigger_record_writer: RTL and testbench
============================================

# tlu_trigger_record_writer

Sequences accepted TLU triggers into fixed 4-word, 32-bit records and buffers them in an internal first-word-fall-through FIFO for readout. Sits in the CLK40 domain of the TLU master, after trigger generation and the trigger-ID/time-stamp counters. It is the single writer of the readout FIFO and decides per trigger whether a full record fits; triggers that do not fit are counted as lost.

## Interface
Parameters:
- DEPTH, 512, FIFO depth in 32-bit words; power of two, ≥ 8
- AW, $clog2(DEPTH), FIFO address width

Ports:
- CLK40  in  1  sole clock
- RST  in  1  synchronous, active-high reset
- ENABLE  in  1  record writing enabled; when 0, TRIG is ignored and not counted
- TRIG  in  1  one-cycle pulse for an accepted trigger
- TIME_STAMP  in  64  time stamp, sampled with TRIG
- TRIG_ID  in  32  trigger ID, sampled with TRIG
- TRIG_LE  in  4  fine leading-edge phase, sampled with TRIG
- VALID  in  4  input-channel hit mask, sampled with TRIG
- FIFO_READ  in  1  pop request
- FIFO_EMPTY  out  1  no words stored
- FIFO_DATA  out  32  head word, valid while FIFO_EMPTY=0
- FIFO_WORDS  out  AW+1  current occupancy
- BUSY  out  1  record write in progress (state ≠ IDLE)
- LOST_DATA_CNT  out  8  saturating count of dropped triggers

## Operation
- Record payload P[119:0] = {16'b0, VALID, TRIG_LE, TRIG_ID, TIME_STAMP}, latched in one snapshot register when TRIG is accepted.
- Word i (i = 0..3) = {i[1:0], P[30i+29:30i]}. Bits [31:30] are the word index, so the reader can resynchronise.
- FSM states: IDLE, W0, W1, W2, W3. W0..W3 each write word i to the FIFO in that cycle. W0→W1→W2→W3 advance unconditionally.
- Accept condition: ENABLE & TRIG & (state==IDLE or state==W3) & free ≥ need.
  - free = DEPTH − FIFO_WORDS.
  - need = 4 in IDLE; need = 5 in W3, because the W3 word is also written that cycle.
  - A read in the same cycle is not credited.
- On accept: snapshot loads and next state is W0. From W3 without accept the next state is IDLE.
- Drop condition: ENABLE & TRIG & not accepted (busy in W0–W2, or insufficient space).
  - LOST_DATA_CNT increments by 1 and saturates at 255.
  - A dropped trigger leaves the snapshot and FSM untouched.
- ENABLE=0 does not abort a record in progress; the record completes.
- FIFO:
  - Pop occurs when FIFO_READ & !FIFO_EMPTY. A read while empty is ignored.
  - Push and pop in the same cycle leave FIFO_WORDS unchanged.
  - FIFO_WORDS never exceeds DEPTH; the accept rule guarantees no overflow.
- A record is never partially written, except when interrupted by RST.

## Timing
- Reset values: state IDLE, FIFO_EMPTY=1, FIFO_WORDS=0, BUSY=0, LOST_DATA_CNT=0. FIFO_DATA is don't-care while empty. The snapshot register is cleared.
- RST mid-record: the record is aborted, the FIFO is flushed and pointers are zeroed the next cycle. Any stored words are discarded.
- Latency: TRIG sampled at edge n → word 0 written at edge n+1, word 3 at edge n+4.
  - FIFO_EMPTY deasserts after edge n+1, assuming the FIFO was empty.
  - FIFO_DATA shows word 0 from that cycle (FWFT).
- Read: FIFO_DATA updates to the next word one cycle after a pop edge. FIFO_WORDS is registered and reflects pushes and pops of the previous edge.
- Maximum sustained rate: one trigger per 4 cycles (accept in W3 → W0 back-to-back). A trigger 1–3 cycles after an accept is dropped.
- BUSY is high in W0..W3 and is combinationally decoded from registered state.
- Simultaneous TRIG and RST: RST wins; nothing is counted.

## Test plan
- Single trigger:
  - Stimulus: after RST, ENABLE=1, TRIG with TIME_STAMP=64'h0123456789ABCDEF, TRIG_ID=32'hDEADBEEF, TRIG_LE=4'h5, VALID=4'hF.
  - Required response: FIFO_WORDS=4 after 4 cycles; reads return {00,P[29:0]}, {01,P[59:30]}, {10,P[89:60]}, {11,P[119:90]} with P as defined; then FIFO_EMPTY=1.
- Back-to-back triggers:
  - Stimulus: TRIG at cycles 0, 4, 8 with IDs 1, 2, 3.
  - Required response: 12 words written contiguously, BUSY high for 12 cycles, LOST_DATA_CNT=0.
- Busy drop:
  - Stimulus: TRIG at cycles 0, 2, 3.
  - Required response: one record (ID of cycle 0) written, LOST_DATA_CNT=2.
- Full FIFO, DEPTH=8:
  - Stimulus: 2 triggers, no reads (FIFO_WORDS=8), then a third trigger.
  - Required response: third trigger dropped, LOST_DATA_CNT=1. After one record is read out, a new trigger is accepted.
- Saturation and disable:
  - Stimulus: 300 drops with FIFO full, then ENABLE=0 with TRIG pulses.
  - Required response: LOST_DATA_CNT stays at 255; no writes and no count change while disabled.
- Reset mid-record:
  - Stimulus: assert RST during W2.
  - Required response: FIFO_EMPTY=1, FIFO_WORDS=0, BUSY=0, LOST_DATA_CNT=0 the next cycle. A new trigger afterwards produces a clean 4-word record starting with index 00.

Source files
------------

// File: rtl/tlu_trigger_record_writer.sv
// TLU trigger record writer: packs accepted triggers into 4-word records
// and buffers them in a first-word-fall-through FIFO for readout.
module tlu_trigger_record_writer #(
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          CLK40,
   input  logic          RST,
   input  logic          ENABLE,
   input  logic          TRIG,
   input  logic [63:0]   TIME_STAMP,
   input  logic [31:0]   TRIG_ID,
   input  logic [3:0]    TRIG_LE,
   input  logic [3:0]    VALID,
   input  logic          FIFO_READ,
   output logic          FIFO_EMPTY,
   output logic [31:0]   FIFO_DATA,
   output logic [AW:0]   FIFO_WORDS,
   output logic          BUSY,
   output logic [7:0]    LOST_DATA_CNT
);

   typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   state_t        state;
   state_t        state_nxt;
   logic [119:0]  snap;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   words;
   logic [AW:0]   free;
   logic [AW:0]   need;
   logic          accept;
   logic          drop;
   logic          push;
   logic          pop;
   logic [31:0]   word;

   // The W3 word lands in the same cycle, so a follow-on record needs one extra slot.
   assign free   = DEPTH_W - words;
   assign need   = (state == W3) ? (AW+1)'(5) : (AW+1)'(4);
   assign accept = ENABLE & TRIG & ((state == IDLE) | (state == W3))
                 & (free >= need);
   assign drop   = ENABLE & TRIG & ~accept;
   assign pop    = FIFO_READ & ~FIFO_EMPTY;

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      word      = '0;
      case (state)
         IDLE: if (accept) state_nxt = W0;
         W0: begin
            push      = 1'b1;
            word      = {2'd0, snap[29:0]};
            state_nxt = W1;
         end
         W1: begin
            push      = 1'b1;
            word      = {2'd1, snap[59:30]};
            state_nxt = W2;
         end
         W2: begin
            push      = 1'b1;
            word      = {2'd2, snap[89:60]};
            state_nxt = W3;
         end
         W3: begin
            push      = 1'b1;
            word      = {2'd3, snap[119:90]};
            state_nxt = accept ? W0 : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK40) begin
      if (RST) begin
         state         <= IDLE;
         snap          <= '0;
         LOST_DATA_CNT <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         words         <= '0;
      end else begin
         state <= state_nxt;
         if (accept)
            snap <= {16'b0, VALID, TRIG_LE, TRIG_ID, TIME_STAMP};
         if (drop && LOST_DATA_CNT != 8'hFF)
            LOST_DATA_CNT <= LOST_DATA_CNT + 8'd1;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   words <= words + 1'b1;
            2'b01:   words <= words - 1'b1;
            default: words <= words;
         endcase
      end
   end

   always_ff @(posedge CLK40) begin
      if (push)
         mem[wr_ptr] <= word;
   end

   assign FIFO_EMPTY = (words == '0);
   assign FIFO_DATA  = mem[rd_ptr];
   assign FIFO_WORDS = words;
   assign BUSY       = (state != IDLE);

endmodule

// File: tb/tb_tlu_trigger_record_writer.sv
// Directed bench for tlu_trigger_record_writer with a word scoreboard,
// run with DEPTH=8 so the full-FIFO cases are reachable quickly.
module tb_tlu_trigger_record_writer;

   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          trig = 1'b0;
   logic [63:0]   ts = '0;
   logic [31:0]   id = '0;
   logic [3:0]    le = '0;
   logic [3:0]    valid = '0;
   logic          rd = 1'b0;
   logic          empty;
   logic [31:0]   data;
   logic [AW:0]   words;
   logic          busy;
   logic [7:0]    lost;

   int            n_cmp = 0;
   int            n_err = 0;
   int            busy_cnt = 0;
   logic [31:0]   sb[$];

   always #5 clk = ~clk;

   tlu_trigger_record_writer #(.DEPTH(DEPTH)) dut (
      .CLK40         (clk),
      .RST           (rst),
      .ENABLE        (enable),
      .TRIG          (trig),
      .TIME_STAMP    (ts),
      .TRIG_ID       (id),
      .TRIG_LE       (le),
      .VALID         (valid),
      .FIFO_READ     (rd),
      .FIFO_EMPTY    (empty),
      .FIFO_DATA     (data),
      .FIFO_WORDS    (words),
      .BUSY          (busy),
      .LOST_DATA_CNT (lost)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: check the head word if popping, then drive this cycle's inputs.
   task automatic cyc(input bit t, input bit r, input bit acc,
                      input logic [31:0] tid);
      logic [119:0] p;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (r && !empty) begin
         chk("sb_has_word", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) chk("fifo_data", 64'(data), 64'(sb.pop_front()));
      end
      trig = t;
      rd   = r;
      id   = tid;
      if (acc) begin
         p = {16'b0, valid, le, tid, ts};
         for (int i = 0; i < 4; i++)
            sb.push_back({i[1:0], p[30*i +: 30]});
      end
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic drain();
      int guard = 0;
      while (!empty && guard < 40) begin
         cyc(1'b0, 1'b1, 1'b0, '0);
         guard++;
      end
      chk("drain_bound", 64'(guard < 40), 64'd1);
      cyc(1'b0, 1'b0, 1'b0, '0);
      chk("drain_empty", 64'(empty), 64'd1);
      chk("drain_sb_left", 64'(sb.size()), 64'd0);
   endtask

   // Reset is applied together with a trigger pulse to show reset wins.
   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      trig = 1'b1;
      rd   = 1'b0;
      @(negedge clk);
      rst  = 1'b0;
      trig = 1'b0;
      sb.delete();
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_words", 64'(words), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_lost", 64'(lost), 64'd0);

      // single trigger
      enable = 1'b1;
      ts     = 64'h0123456789ABCDEF;
      le     = 4'h5;
      valid  = 4'hF;
      cyc(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
      idle(5);
      chk("single_words", 64'(words), 64'd4);
      chk("single_busy", 64'(busy), 64'd0);
      chk("single_word0", 64'(data), 64'h09ABCDEF);
      drain();

      // back-to-back triggers with a concurrent reader
      busy_cnt = 0;
      ts = 64'hFEDCBA9876543210;
      le = 4'hA;
      valid = 4'h3;
      for (int k = 1; k <= 3; k++) begin
         cyc(1'b1, 1'b1, 1'b1, 32'(k));
         if (k < 3) for (int j = 0; j < 3; j++) cyc(1'b0, 1'b1, 1'b0, '0);
      end
      for (int j = 0; j < 8; j++) cyc(1'b0, 1'b1, 1'b0, '0);
      drain();
      chk("b2b_busy_cycles", 64'(busy_cnt), 64'd12);
      chk("b2b_lost", 64'(lost), 64'd0);

      // triggers while busy are dropped
      cyc(1'b1, 1'b0, 1'b1, 32'd10);
      cyc(1'b0, 1'b0, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b0, 32'd11);
      cyc(1'b1, 1'b0, 1'b0, 32'd12);
      idle(3);
      drain();
      chk("busy_drop_lost", 64'(lost), 64'd2);

      // full FIFO
      do_reset();
      chk("rst2_lost", 64'(lost), 64'd0);
      chk("rst2_empty", 64'(empty), 64'd1);
      cyc(1'b1, 1'b0, 1'b1, 32'd20);
      idle(3);
      cyc(1'b1, 1'b0, 1'b1, 32'd21);
      idle(5);
      chk("full_words", 64'(words), 64'd8);
      chk("full_busy", 64'(busy), 64'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'd22);
      idle(1);
      chk("full_lost", 64'(lost), 64'd1);
      chk("full_words_hold", 64'(words), 64'd8);
      for (int j = 0; j < 4; j++) cyc(1'b0, 1'b1, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b1, 32'd23);
      idle(5);
      chk("refill_words", 64'(words), 64'd8);
      chk("refill_lost", 64'(lost), 64'd1);
      drain();

      // saturation, then disable
      cyc(1'b1, 1'b0, 1'b1, 32'd30);
      idle(3);
      cyc(1'b1, 1'b0, 1'b1, 32'd31);
      idle(5);
      for (int j = 0; j < 300; j++) cyc(1'b1, 1'b0, 1'b0, 32'(j));
      idle(1);
      chk("sat_lost", 64'(lost), 64'd255);
      enable = 1'b0;
      for (int j = 0; j < 5; j++) cyc(1'b1, 1'b0, 1'b0, 32'd99);
      idle(1);
      chk("dis_sat_lost", 64'(lost), 64'd255);
      chk("dis_words", 64'(words), 64'd8);
      drain();
      enable = 1'b1;

      // disabling mid-record lets the record complete
      cyc(1'b1, 1'b0, 1'b1, 32'd40);
      cyc(1'b0, 1'b0, 1'b0, '0);
      enable = 1'b0;
      idle(4);
      chk("dis_mid_words", 64'(words), 64'd4);
      drain();
      enable = 1'b1;

      // reset during W2
      cyc(1'b1, 1'b0, 1'b1, 32'd50);
      idle(2);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      do_reset();
      chk("midrst_empty", 64'(empty), 64'd1);
      chk("midrst_words", 64'(words), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_lost", 64'(lost), 64'd0);
      cyc(1'b1, 1'b0, 1'b1, 32'd60);
      idle(5);
      chk("post_rst_words", 64'(words), 64'd4);
      chk("post_rst_idx", 64'(data[31:30]), 64'd0);
      drain();

      // disabled triggers are neither written nor counted
      enable = 1'b0;
      for (int j = 0; j < 3; j++) cyc(1'b1, 1'b0, 1'b0, 32'd70);
      idle(5);
      chk("dis_lost", 64'(lost), 64'd0);
      chk("dis_empty", 64'(empty), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
